sba_core_bus_arbiter: RTL and testbench

//  Shares one data-memory port between the core LSU (port 0) and the debug module SBA host (port 1).

---
 rtl/sba_arb_pkg.sv | 11 +
 rtl/sba_arb_owner_fifo.sv | 66 ++++++
 rtl/sba_core_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_sba_core_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sba_arb_pkg.sv
// Shared types for the core/debug data-memory port arbiter.
package sba_arb_pkg;

    localparam int unsigned NumPorts = 2;

    typedef enum logic {
        OwnerCore = 1'b0,
        OwnerDbg  = 1'b1
    } owner_e;

endpackage

// File: rtl/sba_arb_owner_fifo.sv
// In-order record of which port owns each granted-but-unanswered transaction.
module sba_arb_owner_fifo
    import sba_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic push_owner_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    owner_e          r_mem [Depth];
    logic [PtrW-1:0] r_rd;
    logic [PtrW-1:0] r_wr;
    logic [CntW-1:0] r_cnt;
    logic            w_do_push;
    logic            w_do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o    = (r_cnt == DepthCnt);
    assign empty_o   = (r_cnt == '0);
    assign head_o    = r_mem[r_rd];
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_do_push = push_i && (!full_o || pop_i);
    assign w_do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr] <= owner_e'(push_owner_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= next_ptr(r_wr);
            end
            if (w_do_pop) begin
                r_rd <= next_ptr(r_rd);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/sba_core_bus_arbiter.sv
// Shares one data-memory port between the core LSU (port 0) and the debug SBA host (port 1);
// responses are steered back to their issuer through an in-order owner FIFO.
module sba_core_bus_arbiter
    import sba_arb_pkg::*;
#(
    parameter int unsigned BusWidth       = 32,
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          DbgHighPrio    = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumPorts-1:0]            req_i,
    input  logic [NumPorts*BusWidth-1:0]   add_i,
    input  logic [NumPorts-1:0]            we_i,
    input  logic [NumPorts*BusWidth-1:0]   wdata_i,
    input  logic [NumPorts*BusWidth/8-1:0] be_i,
    output logic [NumPorts-1:0]            gnt_o,
    output logic [NumPorts-1:0]            r_valid_o,
    output logic [BusWidth-1:0]            r_rdata_o,
    output logic                           mem_req_o,
    output logic [BusWidth-1:0]            mem_add_o,
    output logic                           mem_we_o,
    output logic [BusWidth-1:0]            mem_wdata_o,
    output logic [BusWidth/8-1:0]          mem_be_o,
    input  logic                           mem_gnt_i,
    input  logic                           mem_r_valid_i,
    input  logic [BusWidth-1:0]            mem_r_rdata_i,
    output logic                           rsp_err_o
);

    localparam int unsigned BeWidth = BusWidth / 8;

    owner_e w_sel;
    owner_e r_hold_sel;
    owner_e r_last_gnt;
    logic   r_hold;
    logic   r_rsp_err;
    logic   w_req_sel;
    logic   w_gnt;
    logic   w_rsp;
    logic   w_full;
    logic   w_empty;
    logic   w_head;

    // A held choice wins over any new request until the downstream grant arrives.
    always_comb begin
        w_sel = OwnerCore;
        if (r_hold) begin
            w_sel = r_hold_sel;
        end else if (DbgHighPrio) begin
            w_sel = req_i[1] ? OwnerDbg : OwnerCore;
        end else if (req_i[0] && req_i[1]) begin
            w_sel = (r_last_gnt == OwnerCore) ? OwnerDbg : OwnerCore;
        end else if (req_i[1]) begin
            w_sel = OwnerDbg;
        end
    end

    assign w_req_sel = (w_sel == OwnerDbg) ? req_i[1] : req_i[0];
    assign mem_req_o = w_req_sel && !w_full;
    assign w_gnt     = mem_gnt_i && mem_req_o;
    assign gnt_o     = {w_gnt && (w_sel == OwnerDbg), w_gnt && (w_sel == OwnerCore)};

    always_comb begin
        mem_add_o   = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (w_req_sel) begin
            if (w_sel == OwnerDbg) begin
                mem_add_o   = add_i[BusWidth +: BusWidth];
                mem_we_o    = we_i[1];
                mem_wdata_o = wdata_i[BusWidth +: BusWidth];
                mem_be_o    = be_i[BeWidth +: BeWidth];
            end else begin
                mem_add_o   = add_i[0 +: BusWidth];
                mem_we_o    = we_i[0];
                mem_wdata_o = wdata_i[0 +: BusWidth];
                mem_be_o    = be_i[0 +: BeWidth];
            end
        end
    end

    assign w_rsp     = mem_r_valid_i && !w_empty;
    assign r_valid_o = {w_rsp && w_head, w_rsp && !w_head};
    assign r_rdata_o = mem_r_rdata_i;
    assign rsp_err_o = r_rsp_err;

    // Last-granted resets to the debug port so the core has first turn.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_hold     <= 1'b0;
            r_hold_sel <= OwnerCore;
            r_last_gnt <= OwnerDbg;
            r_rsp_err  <= 1'b0;
        end else begin
            r_hold     <= mem_req_o && !mem_gnt_i;
            r_hold_sel <= w_sel;
            if (w_gnt) begin
                r_last_gnt <= w_sel;
            end
            if (mem_r_valid_i && w_empty) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    sba_arb_owner_fifo #(
        .Depth(MaxOutstanding)
    ) u_owner_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_gnt),
        .push_owner_i(w_sel),
        .pop_i       (mem_r_valid_i),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .head_o      (w_head)
    );

endmodule

// File: tb/tb_sba_core_bus_arbiter.sv
// Scenario bench for the core/debug memory-port arbiter: directed cases plus a
// randomized run against a queue-based model of the arbitration rules.
module tb_sba_core_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we;
    logic [31:0] add0, add1, wd0, wd1;
    logic [3:0]  be0, be1;
    logic        mgnt, mrv;
    logic [31:0] mrdata;

    logic [1:0]  gnt, rvalid, gnt_h, rvalid_h;
    logic [31:0] rdata, madd, mwd, rdata_h, madd_h, mwd_h;
    logic        mreq, mwe, err, mreq_h, mwe_h, err_h;
    logic [3:0]  mbe, mbe_h;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    sba_core_bus_arbiter #(
        .BusWidth(32), .MaxOutstanding(2), .DbgHighPrio(1'b0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i({add1, add0}), .we_i(we),
        .wdata_i({wd1, wd0}), .be_i({be1, be0}), .gnt_o(gnt), .r_valid_o(rvalid),
        .r_rdata_o(rdata), .mem_req_o(mreq), .mem_add_o(madd), .mem_we_o(mwe),
        .mem_wdata_o(mwd), .mem_be_o(mbe), .mem_gnt_i(mgnt), .mem_r_valid_i(mrv),
        .mem_r_rdata_i(mrdata), .rsp_err_o(err)
    );

    sba_core_bus_arbiter #(
        .BusWidth(32), .MaxOutstanding(2), .DbgHighPrio(1'b1)
    ) dut_hp (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i({add1, add0}), .we_i(we),
        .wdata_i({wd1, wd0}), .be_i({be1, be0}), .gnt_o(gnt_h), .r_valid_o(rvalid_h),
        .r_rdata_o(rdata_h), .mem_req_o(mreq_h), .mem_add_o(madd_h), .mem_we_o(mwe_h),
        .mem_wdata_o(mwd_h), .mem_be_o(mbe_h), .mem_gnt_i(mgnt), .mem_r_valid_i(mrv),
        .mem_r_rdata_i(mrdata), .rsp_err_o(err_h)
    );

    task automatic clear_inputs();
        req = '0; we = '0; add0 = '0; add1 = '0; wd0 = '0; wd1 = '0;
        be0 = '0; be1 = '0; mgnt = 1'b0; mrv = 1'b0; mrdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (mreq !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mreq); else n_pass++;
        n_checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt got %b want 00", gnt); else n_pass++;
        n_checks++; if (rvalid !== 2'b00) $display("FAIL reset_rvalid got %b want 00", rvalid); else n_pass++;
        n_checks++; if (madd !== 32'h0) $display("FAIL reset_mem_add got %h want 0", madd); else n_pass++;
        n_checks++; if (err !== 1'b0 || err_h !== 1'b0) $display("FAIL reset_err got %b/%b want 0/0", err, err_h); else n_pass++;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        req = 2'b01; add0 = 32'h0000_1000; we = 2'b00; be0 = 4'hF; mgnt = 1'b1;
        #1;
        n_checks++; if (gnt !== 2'b01) $display("FAIL single_gnt got %b want 01", gnt); else n_pass++;
        n_checks++; if (mreq !== 1'b1 || madd !== 32'h1000 || mwe !== 1'b0)
            $display("FAIL single_req got req=%b add=%h we=%b want 1/00001000/0", mreq, madd, mwe); else n_pass++;
        @(negedge clk);
        req = 2'b00; mgnt = 1'b0; mrv = 1'b1; mrdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (rvalid !== 2'b01) $display("FAIL single_rvalid got %b want 01", rvalid); else n_pass++;
        n_checks++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL single_rdata got %h want deadbeef", rdata); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL single_err got %b want 0", err); else n_pass++;
        @(negedge clk);
        mrv = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g, exp_r;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req = 2'b11; mgnt = 1'b1;
            add0 = 32'h100 + k; add1 = 32'h200 + k;
            mrv = (k > 0); mrdata = 32'hA000 + k;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
            #1;
            n_checks++; if (gnt !== exp_g) $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, exp_g); else n_pass++;
            n_checks++; if (madd !== ((k % 2 == 0) ? add0 : add1))
                $display("FAIL rr_add[%0d] got %h want %h", k, madd, (k % 2 == 0) ? add0 : add1); else n_pass++;
            n_checks++; if (rvalid !== exp_r) $display("FAIL rr_rvalid[%0d] got %b want %b", k, rvalid, exp_r); else n_pass++;
        end
    endtask

    task automatic test_hold();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req = (k == 0) ? 2'b01 : 2'b11; add0 = 32'hA0; add1 = 32'hB0; mgnt = 1'b0;
            #1;
            n_checks++; if (madd !== 32'hA0 || gnt !== 2'b00)
                $display("FAIL hold_wait[%0d] got add=%h gnt=%b want 000000a0/00", k, madd, gnt); else n_pass++;
        end
        @(negedge clk);
        mgnt = 1'b1;
        #1;
        n_checks++; if (gnt !== 2'b01 || madd !== 32'hA0)
            $display("FAIL hold_release got gnt=%b add=%h want 01/000000a0", gnt, madd); else n_pass++;
        @(negedge clk);
        req = 2'b10;
        #1;
        n_checks++; if (gnt !== 2'b10 || madd !== 32'hB0)
            $display("FAIL hold_dbg_next got gnt=%b add=%h want 10/000000b0", gnt, madd); else n_pass++;
    endtask

    // Two-deep outstanding limit, draining while full, and same-cycle grant+response.
    task automatic test_full();
        logic [1:0] t_req [11] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b10, 2'b10};
        logic       t_g   [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        logic       t_rv  [11] = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1};
        logic       t_mr  [11] = '{1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1};
        logic [1:0] t_eg  [11] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10};
        logic [1:0] t_er  [11] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01};
        do_reset();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            req = t_req[k]; mgnt = t_g[k]; mrv = t_rv[k]; mrdata = 32'h5500 + k;
            #1;
            n_checks++; if (mreq !== t_mr[k]) $display("FAIL full_mem_req[%0d] got %b want %b", k, mreq, t_mr[k]); else n_pass++;
            n_checks++; if (gnt !== t_eg[k]) $display("FAIL full_gnt[%0d] got %b want %b", k, gnt, t_eg[k]); else n_pass++;
            n_checks++; if (rvalid !== t_er[k]) $display("FAIL full_rvalid[%0d] got %b want %b", k, rvalid, t_er[k]); else n_pass++;
        end
        n_checks++; if (err !== 1'b0) $display("FAIL full_err got %b want 0", err); else n_pass++;
    endtask

    task automatic test_stray_response();
        do_reset();
        @(negedge clk);
        mrv = 1'b1; mrdata = $urandom;
        #1;
        n_checks++; if (rvalid !== 2'b00) $display("FAIL stray_rvalid got %b want 00", rvalid); else n_pass++;
        @(negedge clk);
        mrv = 1'b0;
        #1;
        n_checks++; if (err !== 1'b1) $display("FAIL stray_err_set got %b want 1", err); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (err !== 1'b1) $display("FAIL stray_err_sticky got %b want 1", err); else n_pass++;
        do_reset();
        #1;
        n_checks++; if (err !== 1'b0) $display("FAIL stray_err_clear got %b want 0", err); else n_pass++;
    endtask

    task automatic test_dbg_priority();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req = 2'b11; mgnt = 1'b1; add0 = 32'hC0; add1 = 32'hD0 + k;
            mrv = (k > 0); mrdata = k;
            #1;
            n_checks++; if (gnt_h !== 2'b10 || madd_h !== add1)
                $display("FAIL prio_gnt[%0d] got gnt=%b add=%h want 10/%h", k, gnt_h, madd_h, add1); else n_pass++;
            n_checks++; if (rvalid_h !== ((k > 0) ? 2'b10 : 2'b00))
                $display("FAIL prio_rvalid[%0d] got %b want %b", k, rvalid_h, (k > 0) ? 2'b10 : 2'b00); else n_pass++;
        end
    endtask

    task automatic test_random();
        int         q[$];
        int         last = 1;
        int         hsel = 0;
        int         sel;
        bit         hold = 0;
        bit         pend[2] = '{0, 0};
        bit         ereq;
        logic [1:0] eg, er;
        logic [31:0] eadd, ewd;
        logic        ewe;
        logic [3:0]  ebe;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!pend[0] && $urandom_range(0, 2) == 0) begin
                pend[0] = 1; add0 = $urandom; wd0 = $urandom; be0 = 4'($urandom); we[0] = 1'($urandom);
            end
            if (!pend[1] && $urandom_range(0, 2) == 0) begin
                pend[1] = 1; add1 = $urandom; wd1 = $urandom; be1 = 4'($urandom); we[1] = 1'($urandom);
            end
            req    = {pend[1], pend[0]};
            mgnt   = ($urandom_range(0, 3) != 0);
            mrv    = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            mrdata = $urandom;

            if (hold) sel = hsel;
            else if (req == 2'b11) sel = 1 - last;
            else sel = req[1] ? 1 : 0;
            ereq = req[sel] && (q.size() < 2);
            eg   = (mgnt && ereq) ? ((sel == 1) ? 2'b10 : 2'b01) : 2'b00;
            er   = (mrv && q.size() > 0) ? ((q[0] == 1) ? 2'b10 : 2'b01) : 2'b00;
            eadd = !req[sel] ? 32'h0 : (sel == 1) ? add1 : add0;
            ewd  = !req[sel] ? 32'h0 : (sel == 1) ? wd1 : wd0;
            ebe  = !req[sel] ? 4'h0 : (sel == 1) ? be1 : be0;
            ewe  = req[sel] && we[sel];
            #1;
            n_checks++; if (mreq !== ereq) $display("FAIL rand_mem_req[%0d] got %b want %b", k, mreq, ereq); else n_pass++;
            n_checks++; if (gnt !== eg) $display("FAIL rand_gnt[%0d] got %b want %b", k, gnt, eg); else n_pass++;
            n_checks++; if (rvalid !== er || (er != 0 && rdata !== mrdata))
                $display("FAIL rand_rsp[%0d] got %b/%h want %b/%h", k, rvalid, rdata, er, mrdata); else n_pass++;
            n_checks++; if (madd !== eadd || mwd !== ewd || mbe !== ebe || mwe !== ewe)
                $display("FAIL rand_fields[%0d] got %h/%h/%h/%b want %h/%h/%h/%b",
                         k, madd, mwd, mbe, mwe, eadd, ewd, ebe, ewe); else n_pass++;
            n_checks++; if (err !== 1'b0) $display("FAIL rand_err[%0d] got %b want 0", k, err); else n_pass++;

            if (mrv && q.size() > 0) void'(q.pop_front());
            if (eg != 2'b00) begin
                q.push_back(sel);
                last = sel;
                pend[sel] = 0;
            end
            hold = ereq && !mgnt;
            hsel = sel;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_hold();
        test_full();
        test_stray_response();
        test_dbg_priority();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
